// File: rtl/rv_regs_pkg.sv
// -----------------------------------------------------------------------------
// rv_regs_pkg
// Shared types and constants for the rv_regs_mp multi-port register file.
//   rv_regs_state_t    : controller state (clear sweep / normal operation)
//   RV_REGS_MAX_RD/WR  : upper bounds on read / write port counts
//   rv_regs_first_idx  : first register touched by the clear sweep
// -----------------------------------------------------------------------------
package rv_regs_pkg;

  typedef enum logic {
    RS_INIT = 1'b0,
    RS_RUN  = 1'b1
  } rv_regs_state_t;

  localparam int RV_REGS_MAX_RD = 6;
  localparam int RV_REGS_MAX_WR = 3;

  // Register 0 needs no clearing when it is hardwired to zero.
  function automatic int rv_regs_first_idx(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/rv_regs_mp_if.sv
// -----------------------------------------------------------------------------
// rv_regs_mp_if
// Bundles the read/write port signals of rv_regs_mp.
//   i_rd_addr  NUM_RD*AW     read addresses, port k at [k*AW +: AW]
//   o_rd_data  NUM_RD*WIDTH  read data, port k at [k*WIDTH +: WIDTH]
//   i_wr_en    NUM_WR        per-port write enable
//   i_wr_addr  NUM_WR*AW     write addresses
//   i_wr_data  NUM_WR*WIDTH  write data
//   o_ready    1             high once the post-reset clear sweep is done
// Modports: master (client driving the ports), slave (register file).
// -----------------------------------------------------------------------------
interface rv_regs_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  import rv_regs_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]    i_rd_addr;
  logic [NUM_RD*WIDTH-1:0] o_rd_data;
  logic [NUM_WR-1:0]       i_wr_en;
  logic [NUM_WR*AW-1:0]    i_wr_addr;
  logic [NUM_WR*WIDTH-1:0] i_wr_data;
  logic                    o_ready;

  modport master (
    output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    input  o_rd_data, o_ready
  );

  modport slave (
    input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    output o_rd_data, o_ready
  );

endinterface

// File: rtl/rv_regs_wr_sel.sv
// -----------------------------------------------------------------------------
// rv_regs_wr_sel
// Write-port arbitration for a single register (index IDX).
//   wr_en    in   NUM_WR      per-port write enables (already qualified)
//   wr_addr  in   NUM_WR*AW   per-port write addresses
//   win_oh   out  NUM_WR      one-hot winning port (highest index wins)
//   strobe   out  1           some enabled port addresses this register
// -----------------------------------------------------------------------------
module rv_regs_wr_sel
  import rv_regs_pkg::*;
#(
  parameter int NUM_WR = 1,
  parameter int AW     = 5,
  parameter int IDX    = 0
) (
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  output logic [NUM_WR-1:0]    win_oh,
  output logic                 strobe
);

  localparam logic [AW-1:0] MY_ADDR = AW'(IDX);

  // Ascending scan: a later (higher-index) hit replaces any earlier winner.
  always_comb begin
    win_oh = '0;
    strobe = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] == MY_ADDR)) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        strobe    = 1'b1;
      end else begin
        strobe = strobe;
      end
    end
  end

endmodule

// File: rtl/rv_regs_mp.sv
// -----------------------------------------------------------------------------
// rv_regs_mp
// Parametrised multi-port integer register file (NUM_RD reads, NUM_WR writes).
// After reset a sweep clears one register per cycle; o_ready rises when done
// and writes are honoured only from then on. Reads have one cycle latency.
// Colliding writes to one register: the highest-index enabled port wins.
//   i_clk    in  clock, rising edge
//   i_reset  in  asynchronous active-high reset
//   bus      rv_regs_mp_if.slave (read/write ports, o_ready)
// Optional feature: define RV_REGS_BYPASS_EN to forward same-cycle write data
// to a read of the same address; otherwise such a read returns the old value.
// -----------------------------------------------------------------------------
module rv_regs_mp
  import rv_regs_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  rv_regs_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] FIRST_IDX = AW'(rv_regs_first_idx(ZERO_REG));
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  rv_regs_state_t          state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];

  logic [NUM_WR-1:0]       wr_en_run;
  logic [NUM_WR-1:0]       win_oh [DEPTH];
  logic [DEPTH-1:0]        wr_hit;
  logic [DEPTH-1:0]        wr_strobe;
  logic [WIDTH-1:0]        wr_data_sel [DEPTH];

  assign bus.o_ready   = ready_q;
  assign bus.o_rd_data = rd_data_q;

  // Write enables are ignored while the clear sweep is running.
  assign wr_en_run = (state_q == RS_RUN) ? bus.i_wr_en : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wr_sel
    rv_regs_wr_sel #(
      .NUM_WR (NUM_WR),
      .AW     (AW),
      .IDX    (i)
    ) u_wr_sel (
      .wr_en   (wr_en_run),
      .wr_addr (bus.i_wr_addr),
      .win_oh  (win_oh[i]),
      .strobe  (wr_hit[i])
    );
  end

  // Per-register write strobe and winning data; register 0 drops writes when hardwired.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if ((ZERO_REG != 0) && (i == 0)) begin
        wr_strobe[i] = 1'b0;
      end else begin
        wr_strobe[i] = wr_hit[i];
      end
      wr_data_sel[i] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (win_oh[i][j]) begin
          wr_data_sel[i] = wr_data_sel[i] | bus.i_wr_data[j*WIDTH +: WIDTH];
        end else begin
          wr_data_sel[i] = wr_data_sel[i];
        end
      end
    end
  end

  // State register: FSM, sweep counter, ready flag, read data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= RS_INIT;
      cnt_q     <= FIRST_IDX;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are cleared by the sweep rather than by reset.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // Next-state logic: leave INIT on the edge that clears the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RS_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RS_RUN;
          cnt_d   = cnt_q;
        end else begin
          state_d = RS_INIT;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      RS_RUN: begin
        state_d = RS_RUN;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = RS_INIT;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  // Output logic: o_ready follows the state being entered.
  always_comb begin
    case (state_d)
      RS_RUN:  ready_d = 1'b1;
      RS_INIT: ready_d = 1'b0;
      default: ready_d = 1'b0;
    endcase
  end

  // Storage update: sweep clear in INIT, arbitrated writes in RUN.
  always_comb begin
    mem_d = mem_q;
    if (state_q == RS_INIT) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_strobe[i]) begin
          mem_d[i] = wr_data_sel[i];
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
    end
  end

  // Registered read muxes, one per port.
  always_comb begin
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;
    rd_data_d = '0;
    ra        = '0;
    rv        = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.i_rd_addr[k*AW +: AW];
      rv = mem_q[ra];
`ifdef RV_REGS_BYPASS_EN
      if (wr_strobe[ra]) begin
        rv = wr_data_sel[ra];
      end else begin
        rv = mem_q[ra];
      end
`endif
      if (state_q != RS_RUN) begin
        rv = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rv = '0;
      end else begin
        rv = rv;
      end
      rd_data_d[k*WIDTH +: WIDTH] = rv;
    end
  end

endmodule

// File: tb/tb_rv_regs_mp.sv
// -----------------------------------------------------------------------------
// tb_rv_regs_mp
// Directed bench for rv_regs_mp (WIDTH=32, DEPTH=32, NUM_RD=2, NUM_WR=2,
// ZERO_REG=1). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_rv_regs_mp;
  import rv_regs_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef RV_REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n;

  rv_regs_mp_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  rv_regs_mp #(
    .WIDTH    (W),
    .DEPTH    (D),
    .NUM_RD   (NR),
    .NUM_WR   (NW),
    .ZERO_REG (1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return bus.o_rd_data[k*W +: W];
  endfunction

  task automatic set_rd(input int k, input int a);
    bus.i_rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    bus.i_wr_en[j]            = 1'b1;
    bus.i_wr_addr[j*AW +: AW] = AW'(a);
    bus.i_wr_data[j*W +: W]   = d;
  endtask

  task automatic idle();
    bus.i_wr_en = '0;
  endtask

  initial begin
    bus.i_rd_addr = '0;
    bus.i_wr_en   = '0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_rd0", rd(0), 32'd0);
    check("rst_rd1", rd(1), 32'd0);

    // Release reset, count sweep length; pulse a write to r3 mid-sweep
    rst = 1'b0;
    set_rd(0, 3);
    n = 0;
    while (!bus.o_ready && n < 100) begin
      if (n == 10) wr(0, 3, 32'h0000_00FF);
      else if (n == 11) idle();
      tick();
      n++;
      if (n == 13) check("init_read_r3", rd(0), 32'd0);
    end
    idle();
    check("sweep_len", n, 32'd31);

    // All registers read zero; r3 write during INIT ignored
    for (int a = 0; a < D; a++) begin
      set_rd(0, a);
      set_rd(1, D - 1 - a);
      tick();
      check("clear_p0", rd(0), 32'd0);
      check("clear_p1", rd(1), 32'd0);
    end

    // Basic write then read next cycle, both ports same address
    wr(0, 5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_rd(0, 5);
    set_rd(1, 5);
    tick();
    check("r5_p0", rd(0), 32'hDEAD_BEEF);
    check("r5_p1", rd(1), 32'hDEAD_BEEF);

    // Write to r0 is dropped, also with same-cycle read
    set_rd(0, 0);
    wr(0, 0, 32'h0000_1234);
    tick();
    idle();
    check("r0_same_cycle", rd(0), 32'd0);
    tick();
    check("r0_after", rd(0), 32'd0);

    // Collision: port 1 wins
    wr(0, 7, 32'h0000_0011);
    wr(1, 7, 32'h0000_0022);
    tick();
    idle();
    set_rd(0, 7);
    tick();
    check("collide_r7", rd(0), 32'h0000_0022);

    // Two ports, distinct addresses
    wr(0, 8, 32'h0000_0033);
    wr(1, 9, 32'h0000_0044);
    tick();
    idle();
    set_rd(0, 8);
    set_rd(1, 9);
    tick();
    check("dual_r8", rd(0), 32'h0000_0033);
    check("dual_r9", rd(1), 32'h0000_0044);

    // Same-cycle read and write of r10 (old value 0)
    set_rd(0, 10);
    wr(0, 10, 32'hA5A5_A5A5);
    tick();
    idle();
    check("same_cycle_r10", rd(0), BYP ? 32'hA5A5_A5A5 : 32'd0);
    tick();
    check("after_r10", rd(0), 32'hA5A5_A5A5);

    // Same-cycle read during a collision on r11
    set_rd(1, 11);
    wr(0, 11, 32'h0000_0001);
    wr(1, 11, 32'h0000_0002);
    tick();
    idle();
    check("same_cycle_r11", rd(1), BYP ? 32'h0000_0002 : 32'd0);
    tick();
    check("after_r11", rd(1), 32'h0000_0002);

    // Fill r1..r31 with their index, then read back
    for (int a = 1; a < D; a++) begin
      wr(0, a, 32'(a));
      tick();
    end
    idle();
    for (int a = 0; a < D; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      tick();
      check("fill_p0", rd(0), 32'(a));
      check("fill_p1", rd(1), 32'(a));
    end

    // Asynchronous reset mid-run
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("midrst_rd", rd(0), 32'd0);
    tick();
    rst = 1'b0;
    set_rd(0, 31);
    n = 0;
    while (!bus.o_ready && n < 100) begin
      tick();
      n++;
      if (n == 2) check("init_read_r31", rd(0), 32'd0);
    end
    check("sweep_len2", n, 32'd31);
    for (int a = 0; a < D; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      tick();
      check("reclear_p0", rd(0), 32'd0);
      check("reclear_p1", rd(1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
